// File: rtl/vote_display.sv
// Binary-to-decimal 4-digit multiplexed 7-segment driver with a sequential double-dabble converter.
// Define VOTE_DISPLAY_LZB_EN to blank leading zeros on the upper three digits.
module vote_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        Power,
  input  logic [11:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [27:0]        sr_q, sr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [11:0]        last_q, last_d;
  logic [15:0]        digits_q, digits_d;
  logic               busy_q, busy_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;

  logic [27:0]        adj;
  logic [3:0]         cur_digit;
  logic               blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Converter: the BCD field sits in sr[27:12] and the binary input in sr[11:0].
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    adj      = {add3(sr_q[27:24]), add3(sr_q[23:20]), add3(sr_q[19:16]),
                add3(sr_q[15:12]), sr_q[11:0]};
    case (state_q)
      IDLE: begin
        if (value != last_q) begin
          sr_d    = {16'h0000, value};
          last_d  = value;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) state_d = DONE;
      end
      DONE: begin
        digits_d = sr_q[27:12];
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan divider, digit selection and registered display outputs.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end

    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    blank     = 1'b0;
`ifdef VOTE_DISPLAY_LZB_EN
    case (idx_q)
      2'd1:    blank = (digits_q[15:4]  == 12'h000);
      2'd2:    blank = (digits_q[15:8]  == 8'h00);
      2'd3:    blank = (digits_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    seg_d = blank ? 7'h7F : seg_pattern(cur_digit);
    an_d  = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_vote_display.sv
// Self-checking bench for vote_display: decimal reference model plus randomized conversions.
module tb_vote_display;

  localparam int SD = 4;

  logic        clk;
  logic        Power;
  logic [11:0] value;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int last_v   = 0;

  logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  vote_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .Power(Power), .value(value), .seg(seg), .an(an), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p = pow10(k);
`ifdef VOTE_DISPLAY_LZB_EN
    if (k > 0 && v < p) return 7'h7F;
`endif
    return pat[(v / p) % 10];
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  task automatic run_conversion(input int v, output bit started, output bit finished);
    int n = 0;
    value = 12'(v);
    tick();
    started = (busy === 1'b1);
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    finished = (busy === 1'b0);
    last_v = v;
  endtask

  task automatic read_display(output logic [27:0] segs, output logic [3:0] seen);
    segs = '0;
    seen = '0;
    for (int i = 0; i < 4 * SD + 4; i++) begin
      tick();
      case (an)
        4'hE: begin segs[6:0]   = seg; seen[0] = 1'b1; end
        4'hD: begin segs[13:7]  = seg; seen[1] = 1'b1; end
        4'hB: begin segs[20:14] = seg; seen[2] = 1'b1; end
        4'h7: begin segs[27:21] = seg; seen[3] = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    int idx;
    Power = 1'b1;
    value = 12'd0;
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: seg=%h an=%h busy=%b want seg=7f an=f busy=0", seg, an, busy);
    end
    tick();
    tick();
    Power = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      idx = ((n - 1) / SD) % 4;
      checks++;
      if (an !== ~(4'b0001 << idx) || seg !== exp_seg(0, idx)) begin
        failures++;
        $display("[TB] FAIL scan_step cycle %0d: an=%h seg=%h want an=%h seg=%h",
                 n, an, seg, ~(4'b0001 << idx), exp_seg(0, idx));
      end
    end
    last_v = 0;
  endtask

  task automatic test_max_value;
    int n = 0;
    logic [27:0] segs;
    logic [3:0]  seen;
    value = 12'd4095;
    tick();
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    last_v = 4095;
    checks++;
    if (n != 13) begin
      failures++;
      $display("[TB] FAIL busy_len: got %0d cycles want 13", n);
    end
    checks++;
    if (dut.digits_q !== 16'h4095) begin
      failures++;
      $display("[TB] FAIL digits_4095: got %h want 4095", dut.digits_q);
    end
    read_display(segs, seen);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!seen[k] || segs[k*7 +: 7] !== exp_seg(4095, k)) begin
        failures++;
        $display("[TB] FAIL seg_4095 digit %0d: got %h seen=%b want %h", k, segs[k*7 +: 7], seen[k], exp_seg(4095, k));
      end
    end
  endtask

  task automatic test_toggle_midconv;
    bit ok;
    int n = 0;
    value = 12'd123;
    tick();
    tick();
    tick();
    value = 12'd456;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || dut.digits_q !== 16'h0123) begin
      failures++;
      $display("[TB] FAIL toggle_first: digits=%h busy=%b want 0123 busy=0", dut.digits_q, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL toggle_restart: busy=%b want 1", busy);
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
    last_v = 456;
    checks++;
    if (!ok || dut.digits_q !== 16'h0456) begin
      failures++;
      $display("[TB] FAIL toggle_final: digits=%h done=%b want 0456 done=1", dut.digits_q, ok);
    end
  endtask

  task automatic test_power_midconv;
    int highs = 0;
    logic [27:0] segs;
    logic [3:0]  seen;
    value = 12'd999;
    tick();
    repeat (6) tick();
    Power = 1'b1;
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0 || dut.digits_q !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL power_mid: seg=%h an=%h busy=%b digits=%h want 7f f 0 0000",
               seg, an, busy, dut.digits_q);
    end
    value = 12'd0;
    tick();
    Power = 1'b0;
    last_v = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy === 1'b1) highs++;
    end
    checks++;
    if (highs != 0 || dut.digits_q !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL power_after: busy_cycles=%0d digits=%h want 0 0000", highs, dut.digits_q);
    end
    read_display(segs, seen);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!seen[k] || segs[k*7 +: 7] !== exp_seg(0, k)) begin
        failures++;
        $display("[TB] FAIL seg_zero digit %0d: got %h want %h", k, segs[k*7 +: 7], exp_seg(0, k));
      end
    end
  endtask

  task automatic test_small_values;
    bit st, fin;
    int highs = 0;
    logic [27:0] segs;
    logic [3:0]  seen;
    run_conversion(7, st, fin);
    read_display(segs, seen);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!seen[k] || segs[k*7 +: 7] !== exp_seg(7, k)) begin
        failures++;
        $display("[TB] FAIL seg_seven digit %0d: got %h want %h", k, segs[k*7 +: 7], exp_seg(7, k));
      end
    end
    run_conversion(10, st, fin);
    checks++;
    if (!st || !fin || dut.digits_q !== 16'h0010) begin
      failures++;
      $display("[TB] FAIL digits_10: got %h start=%b done=%b want 0010", dut.digits_q, st, fin);
    end
    run_conversion(9, st, fin);
    checks++;
    if (!st || !fin || dut.digits_q !== 16'h0009) begin
      failures++;
      $display("[TB] FAIL digits_9: got %h start=%b done=%b want 0009", dut.digits_q, st, fin);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("[TB] FAIL idle_hold: busy high %0d cycles want 0", highs);
    end
  endtask

  task automatic test_random;
    bit st, fin;
    int v;
    logic [27:0] segs;
    logic [3:0]  seen;
    for (int it = 0; it < 10; it++) begin
      v = int'($urandom_range(0, 4095));
      if (v == last_v) v = (v + 1) % 4096;
      run_conversion(v, st, fin);
      checks++;
      if (!st || !fin || dut.digits_q !== exp_bcd(v)) begin
        failures++;
        $display("[TB] FAIL rand_digits v=%0d: got %h start=%b done=%b want %h", v, dut.digits_q, st, fin, exp_bcd(v));
      end
      read_display(segs, seen);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (!seen[k] || segs[k*7 +: 7] !== exp_seg(v, k)) begin
          failures++;
          $display("[TB] FAIL rand_seg v=%0d digit %0d: got %h want %h", v, k, segs[k*7 +: 7], exp_seg(v, k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_value();
    test_toggle_midconv();
    test_power_midconv();
    test_small_values();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
